sprite_motion: RTL and testbench
================================

SPRITE_MOTION -- requirements
Module: sprite_motion

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible width in pixels.
REQ-002 SHALL have parameter V_DISPLAY, default 480, visible height in pixels.
REQ-003 SHALL have parameter SPRITE_W, default 160, sprite width in pixels (RATIO*16).
REQ-004 SHALL have parameter SPRITE_H, default 160, sprite height in pixels.
REQ-005 SHALL have parameter STEP, default 2, pixels moved per axis per update; legal range 1..15.
REQ-006 SHALL have parameter FRAME_DIV, default 1, frames per update; legal range 1..255.
REQ-007 SHALL have port CLK  input  1  pixel clock, shared with the VGA timing/render stage.
REQ-008 SHALL have port RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-009 SHALL have port VGA_VS  input  1  active-low vertical sync from the timing stage.
REQ-010 SHALL have port ENABLE  input  1  motion enable, level.
REQ-011 SHALL have port POS_X  output  10  sprite left edge, display coordinates.
REQ-012 SHALL have port POS_Y  output  10  sprite top edge, display coordinates.
REQ-013 SHALL have port POS_VALID  output  1  one-cycle pulse when POS_X/POS_Y update.
REQ-014 SHALL have port BOUNCE  output  1  one-cycle pulse, coincident with POS_VALID, when any axis reversed.
REQ-015 SHALL have port DIR_X, DIR_Y  output  1 each  current direction, 1 = increasing.

Function
REQ-016 SHALL pass VGA_VS through a 2-flop synchronizer; a 1->0 transition of the synchronized signal is a frame tick.
REQ-017 SHALL implement states IDLE, WAIT, MOVE, PUBLISH.
REQ-018 IDLE -> WAIT when ENABLE=1; WAIT -> IDLE when ENABLE=0.
REQ-019 In WAIT, each tick increments frame counter; on the tick where counter = FRAME_DIV-1, counter clears and state -> MOVE.
REQ-020 MOVE (one cycle) SHALL compute next X and Y into internal registers; state -> PUBLISH.
REQ-021 PUBLISH (one cycle) SHALL load POS_X/POS_Y/DIR_X/DIR_Y, pulse POS_VALID (and BOUNCE if reversed); state -> WAIT if ENABLE=1, else IDLE.
REQ-022 Latency: tick detected in cycle T -> POS_VALID high in cycle T+2 (synchronizer delay excluded).
REQ-023 XMAX = H_DISPLAY-SPRITE_W, YMAX = V_DISPLAY-SPRITE_H, computed at elaboration.
REQ-024 Increasing axis: if pos+STEP >= MAX, pos := MAX and direction flips; else pos := pos+STEP.
REQ-025 Decreasing axis: if pos <= STEP, pos := 0 and direction flips; else pos := pos-STEP.
REQ-026 Arithmetic SHALL use 11-bit intermediates; no wrap-around of POS_X/POS_Y ever.
REQ-027 Simultaneous X and Y reversal (corner) SHALL flip both and give a single BOUNCE pulse.
REQ-028 Ticks arriving outside WAIT SHALL be dropped, not counted.
REQ-029 ENABLE falling in MOVE/PUBLISH SHALL let the update complete, then go IDLE; frame counter cleared on entering IDLE.
REQ-030 Outputs SHALL change only in PUBLISH, so coordinates are stable across a rendered frame.

Reset
REQ-031 On RST_N=0, asynchronously: state IDLE, frame counter 0, synchronizer flops 1.
REQ-032 Reset values: POS_X=(H_DISPLAY-SPRITE_W)/2 (240), POS_Y=(V_DISPLAY-SPRITE_H)/2 (160), DIR_X=1, DIR_Y=1, POS_VALID=0, BOUNCE=0.
REQ-033 Reset mid-update SHALL discard the pending update; no POS_VALID pulse follows.

Configuration
REQ-034 Macro SPRITE_COLOR_CYCLE_EN: when defined, adds output SPRITE_RGB (12 bits, reset 12'hF00) that rotates R->G->B->R (F00->0F0->00F->F00) in the PUBLISH cycle carrying BOUNCE; when undefined, port and logic are absent and all else is unchanged.

Structure
REQ-035 Package anim_pkg SHALL hold display dimensions, sprite size defaults, state enum type and 12-bit colour constants.
REQ-036 Sub-module vs_tick SHALL contain synchronizer and falling-edge detector, output 1-cycle tick.

Verification
REQ-037 Reset release, no VGA_VS edges -> POS_X=240, POS_Y=160, DIR_X=DIR_Y=1, no POS_VALID.
REQ-038 ENABLE=1, one VGA_VS fall, STEP=2 -> single POS_VALID, POS_X=242, POS_Y=162, BOUNCE=0.
REQ-039 POS_X=478, DIR_X=1, tick -> POS_X=480, DIR_X=0, BOUNCE=1; next tick -> POS_X=478.
REQ-040 POS_X=480/POS_Y=320 both increasing, tick -> DIR_X=DIR_Y=0, exactly one BOUNCE pulse.
REQ-041 FRAME_DIV=3, six ticks -> exactly two POS_VALID pulses, on ticks 3 and 6.
REQ-042 ENABLE dropped in MOVE -> one POS_VALID, then IDLE; further ticks produce no pulses; RST_N low in MOVE -> no pulse, reset values.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared constants, FSM state type, per-axis step helper and colour palette
// for the sprite animation slice.
package anim_pkg;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned SPRITE_W_DEF  = 160;
  localparam int unsigned SPRITE_H_DEF  = 160;

  localparam int unsigned POS_W  = 10;
  localparam int unsigned CALC_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    MOVE,
    PUBLISH
  } state_t;

  localparam logic [11:0] RGB_RED   = 12'hF00;
  localparam logic [11:0] RGB_GREEN = 12'h0F0;
  localparam logic [11:0] RGB_BLUE  = 12'h00F;

  typedef struct packed {
    logic [CALC_W-1:0] pos;
    logic              dir;
    logic              flip;
  } axis_t;

  // Saturating bounce on one axis; 11-bit arithmetic keeps pos+step from wrapping.
  function automatic axis_t step_axis(input logic [CALC_W-1:0] pos,
                                      input logic              dir,
                                      input logic [CALC_W-1:0] step,
                                      input logic [CALC_W-1:0] max);
    axis_t r;
    r = '0;
    if (dir) begin
      if (pos + step >= max) begin
        r.pos  = max;
        r.dir  = 1'b0;
        r.flip = 1'b1;
      end else begin
        r.pos  = pos + step;
        r.dir  = 1'b1;
      end
    end else begin
      if (pos <= step) begin
        r.pos  = '0;
        r.dir  = 1'b1;
        r.flip = 1'b1;
      end else begin
        r.pos  = pos - step;
        r.dir  = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] next_colour(input logic [11:0] c);
    case (c)
      RGB_RED:   return RGB_GREEN;
      RGB_GREEN: return RGB_BLUE;
      default:   return RGB_RED;
    endcase
  endfunction

endpackage

// File: rtl/vs_tick.sv
// Two-flop synchronizer on the active-low vertical sync plus falling-edge
// detector; o_tick is a single-cycle frame tick.
module vs_tick (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_vs_n,
  output logic o_tick
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_meta   <= i_vs_n;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  always_comb begin
    o_tick = r_sync_d & ~r_sync;
  end

endmodule

// File: rtl/sprite_motion.sv
// Bouncing-sprite position generator, updated once every FRAME_DIV frames.
// Optional macro SPRITE_COLOR_CYCLE_EN adds SPRITE_RGB, rotated on each bounce.
module sprite_motion
  import anim_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned SPRITE_W  = SPRITE_W_DEF,
  parameter int unsigned SPRITE_H  = SPRITE_H_DEF,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VGA_VS,
  input  logic             ENABLE,
  output logic [POS_W-1:0] POS_X,
  output logic [POS_W-1:0] POS_Y,
  output logic             POS_VALID,
  output logic             BOUNCE,
  output logic             DIR_X,
  output logic             DIR_Y
`ifdef SPRITE_COLOR_CYCLE_EN
  ,
  output logic [11:0]      SPRITE_RGB
`endif
);

  localparam logic [CALC_W-1:0] XMAX     = CALC_W'(H_DISPLAY - SPRITE_W);
  localparam logic [CALC_W-1:0] YMAX     = CALC_W'(V_DISPLAY - SPRITE_H);
  localparam logic [POS_W-1:0]  X_INIT   = POS_W'((H_DISPLAY - SPRITE_W) / 2);
  localparam logic [POS_W-1:0]  Y_INIT   = POS_W'((V_DISPLAY - SPRITE_H) / 2);
  localparam logic [CALC_W-1:0] STEP_C   = CALC_W'(STEP);
  localparam logic [7:0]        CNT_LAST = 8'(FRAME_DIV - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_cnt;
  logic             w_tick;
  logic             w_pub;

  logic [POS_W-1:0] r_pos_x;
  logic [POS_W-1:0] r_pos_y;
  logic             r_dir_x;
  logic             r_dir_y;
  logic [POS_W-1:0] r_nx_x;
  logic [POS_W-1:0] r_nx_y;
  logic             r_nx_dx;
  logic             r_nx_dy;
  logic             r_nx_bounce;
  axis_t            w_ax;
  axis_t            w_ay;

  vs_tick u_vs_tick (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_vs_n (VGA_VS),
    .o_tick (w_tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ENABLE) w_next = WAIT;
      WAIT: begin
        if (!ENABLE)                         w_next = IDLE;
        else if (w_tick && r_cnt == CNT_LAST) w_next = MOVE;
      end
      MOVE:    w_next = PUBLISH;
      PUBLISH: w_next = ENABLE ? WAIT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ticks seen outside WAIT never reach the counter, so they are dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (w_next == IDLE) begin
      r_cnt <= '0;
    end else if (r_state == WAIT && w_tick) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_ax = step_axis({1'b0, r_pos_x}, r_dir_x, STEP_C, XMAX);
    w_ay = step_axis({1'b0, r_pos_y}, r_dir_y, STEP_C, YMAX);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_nx_x      <= '0;
      r_nx_y      <= '0;
      r_nx_dx     <= 1'b1;
      r_nx_dy     <= 1'b1;
      r_nx_bounce <= 1'b0;
      r_pos_x     <= X_INIT;
      r_pos_y     <= Y_INIT;
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b1;
    end else begin
      if (r_state == MOVE) begin
        r_nx_x      <= w_ax.pos[POS_W-1:0];
        r_nx_y      <= w_ay.pos[POS_W-1:0];
        r_nx_dx     <= w_ax.dir;
        r_nx_dy     <= w_ay.dir;
        r_nx_bounce <= w_ax.flip | w_ay.flip;
      end
      if (r_state == PUBLISH) begin
        r_pos_x <= r_nx_x;
        r_pos_y <= r_nx_y;
        r_dir_x <= r_nx_dx;
        r_dir_y <= r_nx_dy;
      end
    end
  end

  // New values are presented during PUBLISH itself (tick + 2) and retained afterwards.
  always_comb begin
    w_pub     = (r_state == PUBLISH);
    POS_VALID = w_pub;
    BOUNCE    = w_pub & r_nx_bounce;
    POS_X     = w_pub ? r_nx_x  : r_pos_x;
    POS_Y     = w_pub ? r_nx_y  : r_pos_y;
    DIR_X     = w_pub ? r_nx_dx : r_dir_x;
    DIR_Y     = w_pub ? r_nx_dy : r_dir_y;
  end

`ifdef SPRITE_COLOR_CYCLE_EN
  logic [11:0] r_rgb;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                        r_rgb <= RGB_RED;
    else if (w_pub && r_nx_bounce)     r_rgb <= next_colour(r_rgb);
  end

  always_comb begin
    SPRITE_RGB = (w_pub && r_nx_bounce) ? next_colour(r_rgb) : r_rgb;
  end
`endif

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: three instances (defaults, FRAME_DIV=3,
// square display so both axes reach the corner together).
module tb_sprite_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b1;
  logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic       pv_a, bo_a, dx_a, dy_a;
  logic       pv_b, bo_b, dx_b, dy_b;
  logic       pv_c, bo_c, dx_c, dy_c;
`ifdef SPRITE_COLOR_CYCLE_EN
  logic [11:0] rgb_a, rgb_b, rgb_c;
`endif

  int total = 0;
  int bad = 0;
  int nv_a = 0, nb_a = 0, nv_b = 0, nv_c = 0, nb_c = 0;
  logic lb_a = 1'b0;
  int first_valid = -1;

  always #5 clk = ~clk;

  sprite_motion dut_a (
    .CLK(clk), .RST_N(rst_n), .VGA_VS(vs), .ENABLE(en_a),
    .POS_X(x_a), .POS_Y(y_a), .POS_VALID(pv_a), .BOUNCE(bo_a),
    .DIR_X(dx_a), .DIR_Y(dy_a)
`ifdef SPRITE_COLOR_CYCLE_EN
    , .SPRITE_RGB(rgb_a)
`endif
  );

  sprite_motion #(.FRAME_DIV(3)) dut_b (
    .CLK(clk), .RST_N(rst_n), .VGA_VS(vs), .ENABLE(en_b),
    .POS_X(x_b), .POS_Y(y_b), .POS_VALID(pv_b), .BOUNCE(bo_b),
    .DIR_X(dx_b), .DIR_Y(dy_b)
`ifdef SPRITE_COLOR_CYCLE_EN
    , .SPRITE_RGB(rgb_b)
`endif
  );

  sprite_motion #(.V_DISPLAY(640)) dut_c (
    .CLK(clk), .RST_N(rst_n), .VGA_VS(vs), .ENABLE(en_c),
    .POS_X(x_c), .POS_Y(y_c), .POS_VALID(pv_c), .BOUNCE(bo_c),
    .DIR_X(dx_c), .DIR_Y(dy_c)
`ifdef SPRITE_COLOR_CYCLE_EN
    , .SPRITE_RGB(rgb_c)
`endif
  );

  always @(negedge clk) begin
    if (pv_a) begin
      nv_a <= nv_a + 1;
      lb_a <= bo_a;
      if (bo_a) nb_a <= nb_a + 1;
    end
    if (pv_b) nv_b <= nv_b + 1;
    if (pv_c) begin
      nv_c <= nv_c + 1;
      if (bo_c) nb_c <= nb_c + 1;
    end
  end

  // One VGA_VS low pulse; optionally drops en_a or asserts reset at a given
  // negedge index after the fall (index 3 lands in the MOVE cycle).
  task automatic vs_event(input int drop_at, input int rst_at);
    first_valid = -1;
    vs = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == drop_at) en_a = 1'b0;
      if (i == rst_at) rst_n = 1'b0;
      if (first_valid < 0 && pv_a) first_valid = i;
    end
    vs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (x_a !== 10'd240) begin bad++; $display("FAIL reset_x: got %0d want 240", x_a); end
    total++; if (y_a !== 10'd160) begin bad++; $display("FAIL reset_y: got %0d want 160", y_a); end
    total++; if ({dx_a, dy_a} !== 2'b11) begin bad++; $display("FAIL reset_dir: got %b want 11", {dx_a, dy_a}); end
    total++; if (y_c !== 10'd240) begin bad++; $display("FAIL reset_y_square: got %0d want 240", y_c); end
    en_a = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (nv_a !== 0) begin bad++; $display("FAIL reset_no_valid: got %0d pulses want 0", nv_a); end
    total++; if (pv_a !== 1'b0 || bo_a !== 1'b0) begin bad++; $display("FAIL reset_pulses: got valid=%b bounce=%b want 0 0", pv_a, bo_a); end
  endtask

  task automatic test_single_step;
    vs_event(0, 0);
    total++; if (nv_a !== 1) begin bad++; $display("FAIL step_count: got %0d pulses want 1", nv_a); end
    total++; if (x_a !== 10'd242 || y_a !== 10'd162) begin bad++; $display("FAIL step_pos: got %0d,%0d want 242,162", x_a, y_a); end
    total++; if (nb_a !== 0) begin bad++; $display("FAIL step_bounce: got %0d want 0", nb_a); end
    total++; if (first_valid !== 4) begin bad++; $display("FAIL step_latency: got %0d want 4", first_valid); end
  endtask

  task automatic test_x_bounce;
    for (int n = 2; n <= 119; n++) begin
      vs_event(0, 0);
      if (n == 80) begin
        total++; if (y_a !== 10'd320 || dy_a !== 1'b0 || nb_a !== 1) begin
          bad++; $display("FAIL y_bounce: got y=%0d dy=%b bounces=%0d want 320 0 1", y_a, dy_a, nb_a); end
      end
    end
    total++; if (x_a !== 10'd478 || dx_a !== 1'b1) begin bad++; $display("FAIL pre_x_bounce: got x=%0d dx=%b want 478 1", x_a, dx_a); end
    vs_event(0, 0);
    total++; if (x_a !== 10'd480 || dx_a !== 1'b0) begin bad++; $display("FAIL x_bounce: got x=%0d dx=%b want 480 0", x_a, dx_a); end
    total++; if (lb_a !== 1'b1 || nb_a !== 2) begin bad++; $display("FAIL x_bounce_pulse: got last=%b bounces=%0d want 1 2", lb_a, nb_a); end
    total++; if (y_a !== 10'd240) begin bad++; $display("FAIL x_bounce_y: got %0d want 240", y_a); end
    vs_event(0, 0);
    total++; if (x_a !== 10'd478 || y_a !== 10'd238 || lb_a !== 1'b0) begin
      bad++; $display("FAIL after_x_bounce: got x=%0d y=%0d bounce=%b want 478 238 0", x_a, y_a, lb_a); end
    total++; if (nv_a !== 121) begin bad++; $display("FAIL x_count: got %0d want 121", nv_a); end
`ifdef SPRITE_COLOR_CYCLE_EN
    total++; if (rgb_a !== 12'h00F) begin bad++; $display("FAIL rgb_cycle: got %h want 00f", rgb_a); end
`endif
    en_a = 1'b0;
  endtask

  task automatic test_corner;
    en_c = 1'b1;
    repeat (2) @(negedge clk);
    for (int n = 1; n <= 119; n++) vs_event(0, 0);
    total++; if (x_c !== 10'd478 || y_c !== 10'd478 || nb_c !== 0) begin
      bad++; $display("FAIL pre_corner: got %0d,%0d bounces=%0d want 478,478 0", x_c, y_c, nb_c); end
    vs_event(0, 0);
    total++; if (x_c !== 10'd480 || y_c !== 10'd480) begin bad++; $display("FAIL corner_pos: got %0d,%0d want 480,480", x_c, y_c); end
    total++; if ({dx_c, dy_c} !== 2'b00) begin bad++; $display("FAIL corner_dir: got %b want 00", {dx_c, dy_c}); end
    total++; if (nb_c !== 1 || nv_c !== 120) begin bad++; $display("FAIL corner_pulses: got bounces=%0d valids=%0d want 1 120", nb_c, nv_c); end
    en_c = 1'b0;
  endtask

  task automatic test_frame_div;
    int exp_v;
    en_b = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      vs_event(0, 0);
      exp_v = k / 3;
      total++; if (nv_b !== exp_v) begin bad++; $display("FAIL div_count_tick%0d: got %0d want %0d", k, nv_b, exp_v); end
      if (k == 3) begin
        total++; if (x_b !== 10'd242 || y_b !== 10'd162) begin bad++; $display("FAIL div_pos3: got %0d,%0d want 242,162", x_b, y_b); end
      end
    end
    total++; if (x_b !== 10'd244) begin bad++; $display("FAIL div_pos6: got %0d want 244", x_b); end
    en_b = 1'b0;
  endtask

  task automatic test_drop_and_reset;
    int base;
    en_a = 1'b1;
    repeat (2) @(negedge clk);
    base = nv_a;
    vs_event(3, 0);
    total++; if (nv_a !== base + 1) begin bad++; $display("FAIL drop_one_valid: got %0d want %0d", nv_a, base + 1); end
    total++; if (x_a !== 10'd476 || y_a !== 10'd236) begin bad++; $display("FAIL drop_pos: got %0d,%0d want 476,236", x_a, y_a); end
    vs_event(0, 0);
    vs_event(0, 0);
    total++; if (nv_a !== base + 1 || x_a !== 10'd476) begin
      bad++; $display("FAIL drop_idle: got valids=%0d x=%0d want %0d 476", nv_a, x_a, base + 1); end
    en_a = 1'b1;
    repeat (2) @(negedge clk);
    vs_event(0, 3);
    total++; if (nv_a !== base + 1) begin bad++; $display("FAIL rst_move_valid: got %0d want %0d", nv_a, base + 1); end
    total++; if (x_a !== 10'd240 || y_a !== 10'd160 || {dx_a, dy_a} !== 2'b11) begin
      bad++; $display("FAIL rst_move_vals: got %0d,%0d dir=%b want 240,160 11", x_a, y_a, {dx_a, dy_a}); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (nv_a !== base + 1) begin bad++; $display("FAIL rst_release_valid: got %0d want %0d", nv_a, base + 1); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_x_bounce();
    test_corner();
    test_frame_div();
    test_drop_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete within 2 ms");
    $fatal(1);
  end

endmodule
